// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// Module   : dmem_responder
// Brief    : Data-memory slave: one request at a time, fixed access latency,
//            response over a valid/ready handshake with backpressure.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_write,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_busy
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(LATENCY - 1);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_op_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rsp_write;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic                w_commit;

    assign w_accept = (r_state == S_IDLE) && i_req_valid;
    assign w_commit = (r_state == S_WAIT) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_req_valid)  w_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0)  w_next = S_RESP;
            S_RESP:  if (i_rsp_ready)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_op_write  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_write <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt      <= C_CNT_INIT;
                r_op_write <= i_req_write;
                r_addr     <= i_req_addr;
                r_wdata    <= i_req_wdata;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // The response word is captured at the commit edge and then frozen through RESP.
            if (w_commit) begin
                r_rdata     <= r_op_write ? r_wdata : r_mem[r_addr];
                r_rsp_write <= r_op_write;
            end
        end
    end

    // Storage is never reset; an aborted store never reaches the commit edge.
    always_ff @(posedge clk) begin
        if (w_commit && r_op_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign o_req_ready = (r_state == S_IDLE) && rst_n;
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_write = r_rsp_write;
    assign o_rsp_rdata = r_rdata;
    assign o_busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core: it is the slave end of the memory-stage load/store request channel. It accepts one word request at a time over a valid/ready handshake, models a configurable access latency, commits writes and reads a word-addressed array, and returns a response over a second valid/ready handshake. `busy` feeds the hazard unit so the memory stage stalls while a transaction is outstanding.

## Interface
**Parameters**
- `DATA_W`, default 32: word width.
- `ADDR_W`, default 8: word-address width; array depth is 2^ADDR_W.
- `LATENCY`, default 2: cycles from request accept to response valid. Legal range is LATENCY ≥ 1.

**Ports**
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the block can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: store data.
- `rsp_valid` out 1: a response is presented.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_write` out 1: echoes the op of the request being answered.
- `rsp_rdata` out DATA_W: for loads, the word read; for stores, the word written.
- `busy` out 1: a transaction is outstanding; drives the memory-stage stall.

## Operation
**Storage**
- Array of 2^ADDR_W × DATA_W words.
- Array contents are not reset.
- There is no out-of-range address; address arithmetic never wraps into a neighbouring word.

**FSM states**
- IDLE:
  - req_ready = 1.
  - On `req_valid & req_ready`, latch op, addr, wdata; load the wait counter with LATENCY-1; go to WAIT.
- WAIT:
  - req_ready = 0.
  - When the counter is nonzero, decrement it.
  - When the counter is 0, perform the access at that edge (store: array[addr] ← wdata and rsp_rdata ← wdata; load: rsp_rdata ← array[addr]), set rsp_write; go to RESP.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_write are held stable.
  - On `rsp_valid & rsp_ready`, go to IDLE.
  - A new request is not accepted in the same cycle; req_ready rises only in IDLE.

**Derived outputs**
- busy = (state ≠ IDLE).
- req_ready = (state == IDLE), forced to 0 while rst is low.

**Rules and boundary conditions**
- Exactly one outstanding transaction.
- A request presented while busy is ignored. The requester must hold it, stable, until req_ready.
- Response backpressure: rsp_valid stays high and the data stays frozen for as long as rsp_ready stays low.
- Load after store to the same address returns the new data, because the store commits before the load is accepted.

**Reset**
- Asynchronous assertion forces IDLE, rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, busy = 0, and clears the counter.
- Reset mid-WAIT aborts the transaction. A store that has not reached its commit edge is not written.
- Reset mid-RESP drops the response.
- Release of rst is synchronous to the design: the first accept can occur on the first rising edge after deassertion.

## Timing
- Request accepted at edge T ⇒ access commits at edge T+LATENCY ⇒ rsp_valid high from edge T+LATENCY.
- Earliest response handshake is edge T+LATENCY+1 (rsp_ready held high). IDLE is re-entered at that edge; the next accept is at T+LATENCY+2.
- Back-to-back throughput: one transaction per LATENCY+2 cycles.
- For LATENCY = 1, WAIT lasts exactly one cycle.
- All outputs are registered or decoded purely from state. There is no combinational path from req_* or rsp_ready to any output.

## Test plan
- **Basic store/load**, LATENCY = 2:
  - Store 0xDEADBEEF to 0x10 with rsp_ready = 1. Expect rsp_valid exactly 2 cycles after accept, rsp_write = 1, rsp_rdata = 0xDEADBEEF.
  - Then load 0x10. Expect rsp_rdata = 0xDEADBEEF, rsp_write = 0.
- **Request while busy**:
  - Hold req_valid with a second store (0x11 ← 0x1) during WAIT/RESP.
  - Expect req_ready = 0 and busy = 1 throughout, and the second request accepted only in the IDLE cycle.
  - A later load of 0x11 returns 0x1.
- **Response backpressure**:
  - Hold rsp_ready = 0 for 5 cycles during a load of 0x10.
  - Expect rsp_valid held high, rsp_rdata stable at 0xDEADBEEF, and no new accept.
  - Release rsp_ready: expect IDLE on the next edge.
- **Reset mid-WAIT**:
  - Store 0x22 ← 0xA5A5A5A5 (prior value 0x0), then assert rst before the commit edge.
  - Expect all outputs at reset values immediately.
  - After release, a load of 0x22 returns 0x0.
- **Latency sweep and boundary addresses**:
  - LATENCY = 1 and LATENCY = 4. Store 0xFF ← 0x12345678 and 0x00 ← 0x9ABCDEF0.
  - Expect loads to return the respective values with response delays of 1 and 4 cycles.
  - Expect the two addresses not to alias.
